// File: rtl/axi4_mem_slave.sv
// AXI4 INCR-burst memory slave with independent write and read channel FSMs over a word RAM.
// Optional macro AXI4_WSTRB_EN adds the WSTRB byte-lane write enable input.
module axi4_mem_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
`ifdef AXI4_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
`endif
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = $clog2(MEMORY_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rState_t;

  logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];

  // Flags a burst that leaves the RAM, crosses a 4 KB page, or is wider than the bus.
  function automatic logic calcErr(input logic [ADDR_WIDTH-1:0] addr,
                                   input logic [7:0] len,
                                   input logic [2:0] size);
    logic [31:0] idxEnd;
    logic [31:0] pageEnd;
    idxEnd  = 32'(addr >> OFFS) + 32'(len);
    pageEnd = 32'(addr[11:0]) + ((32'(len) + 32'd1) << size);
    return (idxEnd >= 32'(MEMORY_DEPTH)) || (pageEnd > 32'd4096) || (32'(size) > 32'(OFFS));
  endfunction

  wState_t               r_wState, w_wStateNext;
  logic [ADDR_WIDTH-1:0] r_wAddr, w_wAddrNext;
  logic [7:0]            r_wLen, w_wLenNext;
  logic [2:0]            r_wSize, w_wSizeNext;
  logic [7:0]            r_wCnt, w_wCntNext;
  logic                  r_wErr, w_wErrNext;
  logic                  r_wProtoErr, w_wProtoErrNext;
  logic                  r_awready, w_awreadyNext;
  logic                  r_wready, w_wreadyNext;
  logic                  r_bvalid, w_bvalidNext;
  logic [1:0]            r_bresp, w_brespNext;
  logic                  w_wHs;
  logic                  w_wFinal;
  logic                  w_memWe;
  logic [IDXW-1:0]       w_wIdx;

  assign w_wHs    = (r_wState == W_DATA) && WVALID && r_wready;
  assign w_wFinal = (r_wCnt == r_wLen);
  assign w_memWe  = w_wHs && !r_wErr;
  assign w_wIdx   = r_wAddr[OFFS +: IDXW];

  // Write channel next-state; a WLAST mismatch only poisons the response, not the data.
  always_comb begin
    w_wStateNext    = r_wState;
    w_wAddrNext     = r_wAddr;
    w_wLenNext      = r_wLen;
    w_wSizeNext     = r_wSize;
    w_wCntNext      = r_wCnt;
    w_wErrNext      = r_wErr;
    w_wProtoErrNext = r_wProtoErr;
    case (r_wState)
      W_IDLE: begin
        if (AWVALID && r_awready) begin
          w_wAddrNext     = AWADDR;
          w_wLenNext      = AWLEN;
          w_wSizeNext     = AWSIZE;
          w_wErrNext      = calcErr(AWADDR, AWLEN, AWSIZE);
          w_wProtoErrNext = 1'b0;
          w_wCntNext      = 8'd0;
          w_wStateNext    = W_DATA;
        end
      end
      W_DATA: begin
        if (w_wHs) begin
          if (WLAST != w_wFinal) w_wProtoErrNext = 1'b1;
          w_wAddrNext = r_wAddr + (ADDR_WIDTH'(1) << r_wSize);
          w_wCntNext  = r_wCnt + 8'd1;
          if (w_wFinal) w_wStateNext = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY && r_bvalid) w_wStateNext = W_IDLE;
      end
      default: w_wStateNext = W_IDLE;
    endcase
    w_awreadyNext = (w_wStateNext == W_IDLE);
    w_wreadyNext  = (w_wStateNext == W_DATA);
    w_bvalidNext  = (w_wStateNext == W_RESP);
    w_brespNext   = (w_bvalidNext && (w_wErrNext || w_wProtoErrNext)) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wState    <= W_IDLE;
      r_wAddr     <= '0;
      r_wLen      <= 8'd0;
      r_wSize     <= 3'd0;
      r_wCnt      <= 8'd0;
      r_wErr      <= 1'b0;
      r_wProtoErr <= 1'b0;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= 2'b00;
    end else begin
      r_wState    <= w_wStateNext;
      r_wAddr     <= w_wAddrNext;
      r_wLen      <= w_wLenNext;
      r_wSize     <= w_wSizeNext;
      r_wCnt      <= w_wCntNext;
      r_wErr      <= w_wErrNext;
      r_wProtoErr <= w_wProtoErrNext;
      r_awready   <= w_awreadyNext;
      r_wready    <= w_wreadyNext;
      r_bvalid    <= w_bvalidNext;
      r_bresp     <= w_brespNext;
    end
  end

  // RAM contents survive reset so an aborted burst keeps its written beats.
  always_ff @(posedge ACLK) begin
    if (w_memWe) begin
`ifdef AXI4_WSTRB_EN
      for (int b = 0; b < BYTES; b++) begin
        if (WSTRB[b]) r_mem[w_wIdx][8*b +: 8] <= WDATA[8*b +: 8];
      end
`else
      r_mem[w_wIdx] <= WDATA;
`endif
    end
  end

  rState_t               r_rState, w_rStateNext;
  logic [ADDR_WIDTH-1:0] r_rAddr, w_rAddrNext;
  logic [7:0]            r_rLen, w_rLenNext;
  logic [2:0]            r_rSize, w_rSizeNext;
  logic [7:0]            r_rCnt, w_rCntNext;
  logic                  r_rErr, w_rErrNext;
  logic                  r_arready, w_arreadyNext;
  logic                  r_rvalid, w_rvalidNext;
  logic                  r_rlast, w_rlastNext;
  logic [1:0]            r_rresp, w_rrespNext;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdataNext;
  logic [IDXW-1:0]       w_rIdx;

  assign w_rIdx = r_rAddr[OFFS +: IDXW];

  // Read channel next-state; the RAM word is captured straight into RDATA on leaving R_FETCH.
  always_comb begin
    w_rStateNext = r_rState;
    w_rAddrNext  = r_rAddr;
    w_rLenNext   = r_rLen;
    w_rSizeNext  = r_rSize;
    w_rCntNext   = r_rCnt;
    w_rErrNext   = r_rErr;
    w_rdataNext  = r_rdata;
    w_rrespNext  = r_rresp;
    w_rlastNext  = r_rlast;
    case (r_rState)
      R_IDLE: begin
        if (ARVALID && r_arready) begin
          w_rAddrNext  = ARADDR;
          w_rLenNext   = ARLEN;
          w_rSizeNext  = ARSIZE;
          w_rErrNext   = calcErr(ARADDR, ARLEN, ARSIZE);
          w_rCntNext   = 8'd0;
          w_rStateNext = R_FETCH;
        end
      end
      R_FETCH: begin
        w_rdataNext  = r_rErr ? '0 : r_mem[w_rIdx];
        w_rrespNext  = r_rErr ? 2'b10 : 2'b00;
        w_rlastNext  = (r_rCnt == r_rLen);
        w_rStateNext = R_DATA;
      end
      R_DATA: begin
        if (RREADY && r_rvalid) begin
          w_rdataNext = '0;
          w_rrespNext = 2'b00;
          w_rlastNext = 1'b0;
          if (r_rlast) begin
            w_rStateNext = R_IDLE;
          end else begin
            w_rAddrNext  = r_rAddr + (ADDR_WIDTH'(1) << r_rSize);
            w_rCntNext   = r_rCnt + 8'd1;
            w_rStateNext = R_FETCH;
          end
        end
      end
      default: w_rStateNext = R_IDLE;
    endcase
    w_arreadyNext = (w_rStateNext == R_IDLE);
    w_rvalidNext  = (w_rStateNext == R_DATA);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rState  <= R_IDLE;
      r_rAddr   <= '0;
      r_rLen    <= 8'd0;
      r_rSize   <= 3'd0;
      r_rCnt    <= 8'd0;
      r_rErr    <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
    end else begin
      r_rState  <= w_rStateNext;
      r_rAddr   <= w_rAddrNext;
      r_rLen    <= w_rLenNext;
      r_rSize   <= w_rSizeNext;
      r_rCnt    <= w_rCntNext;
      r_rErr    <= w_rErrNext;
      r_arready <= w_arreadyNext;
      r_rvalid  <= w_rvalidNext;
      r_rlast   <= w_rlastNext;
      r_rresp   <= w_rrespNext;
      r_rdata   <= w_rdataNext;
    end
  end

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RLAST   = r_rlast;
  assign RRESP   = r_rresp;
  assign RDATA   = r_rdata;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: a byte-address memory model predicts every B and R beat,
// a negedge compare process checks them each valid cycle, and literal checks pin key results.
module tb_axi4_mem_slave;
  localparam int DEPTH   = 1024;
  localparam int TIMEOUT = 200;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
`ifdef AXI4_WSTRB_EN
  logic [3:0]  WSTRB = 4'hF;
`endif
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [15:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  always #5 ACLK = ~ACLK;

  axi4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA),
`ifdef AXI4_WSTRB_EN
    .WSTRB(WSTRB),
`endif
    .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rBeat_t;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] modelMem [DEPTH];
  logic [31:0] wBuf [16];
  logic [1:0]  expB [$];
  logic [1:0]  gotB [$];
  rBeat_t      expR [$];
  rBeat_t      gotR [$];
  rBeat_t      cmpBeat;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic failNote(input string name, input string actual, input string expected);
    checks++;
    fails++;
    $display("[TB] FAIL %s: actual=%s expected=%s", name, actual, expected);
  endtask

  // Burst legality from first principles: word span, 4 KB page span, and beat width.
  function automatic bit modelErr(input int addr, input int len, input int size);
    int bytes;
    bytes = 1 << size;
    return ((addr / 4 + len) >= DEPTH) || ((addr % 4096) + (len + 1) * bytes > 4096) || (size > 2);
  endfunction

  // ch: 0 AWREADY, 1 WREADY, 2 BVALID, 3 ARREADY, 4 RVALID
  task automatic waitHs(input int ch, input string name, input bit toEdge);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < TIMEOUT) begin
      @(negedge ACLK);
      case (ch)
        0: seen = AWREADY;
        1: seen = WREADY;
        2: seen = BVALID;
        3: seen = ARREADY;
        default: seen = RVALID;
      endcase
      n++;
    end
    if (!seen) failNote({"timeout ", name}, "no handshake", "handshake within budget");
    if (toEdge) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit isWrite, input int addr, input int len, input int size,
                               input int badLast, input int stallBeat, input int stall);
    bit     err;
    rBeat_t e;
    err = modelErr(addr, len, size);
    if (isWrite) begin
      expB.push_back((err || badLast >= 0) ? 2'b10 : 2'b00);
      AWADDR = 16'(addr); AWLEN = 8'(len); AWSIZE = 3'(size); AWVALID = 1'b1;
      waitHs(0, "AW", 1'b1);
      AWVALID = 1'b0;
      for (int b = 0; b <= len; b++) begin
        WDATA  = wBuf[b];
        WLAST  = (b == len) ^ (b == badLast);
        WVALID = 1'b1;
        waitHs(1, "W", 1'b1);
        if (!err) modelMem[(addr + b * (1 << size)) / 4] = wBuf[b];
      end
      WVALID = 1'b0;
      WLAST  = 1'b0;
      if (stall > 0) begin
        waitHs(2, "B valid", 1'b0);
        repeat (stall) @(posedge ACLK);
        #1;
      end
      BREADY = 1'b1;
      waitHs(2, "B", 1'b1);
      BREADY = 1'b0;
    end else begin
      for (int b = 0; b <= len; b++) begin
        e.data = err ? 32'h0 : modelMem[(addr + b * (1 << size)) / 4];
        e.resp = err ? 2'b10 : 2'b00;
        e.last = (b == len);
        expR.push_back(e);
      end
      ARADDR = 16'(addr); ARLEN = 8'(len); ARSIZE = 3'(size); ARVALID = 1'b1;
      waitHs(3, "AR", 1'b1);
      ARVALID = 1'b0;
      for (int b = 0; b <= len; b++) begin
        if (b == stallBeat) begin
          RREADY = 1'b0;
          waitHs(4, "R valid", 1'b0);
          repeat (stall) @(posedge ACLK);
          #1;
        end
        RREADY = 1'b1;
        waitHs(4, "R", 1'b1);
      end
      RREADY = 1'b0;
    end
  endtask

  // Every cycle a response is valid it must equal the oldest predicted one; pops on handshake.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (BVALID) begin
        if (expB.size() == 0) failNote("B extra", "BVALID", "no response pending");
        else begin
          checkOutput("BRESP", 32'(BRESP), 32'(expB[0]));
          if (BREADY) begin
            gotB.push_back(BRESP);
            void'(expB.pop_front());
          end
        end
      end
      if (RVALID) begin
        if (expR.size() == 0) failNote("R extra", "RVALID", "no beat pending");
        else begin
          checkOutput("RDATA", RDATA, expR[0].data);
          checkOutput("RRESP", 32'(RRESP), 32'(expR[0].resp));
          checkOutput("RLAST", 32'(RLAST), 32'(expR[0].last));
          if (RREADY) begin
            cmpBeat.data = RDATA;
            cmpBeat.resp = RRESP;
            cmpBeat.last = RLAST;
            gotR.push_back(cmpBeat);
            void'(expR.pop_front());
          end
        end
      end
    end
  end

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " AWREADY"}, 32'(AWREADY), 0);
    checkOutput({tag, " WREADY"},  32'(WREADY),  0);
    checkOutput({tag, " BVALID"},  32'(BVALID),  0);
    checkOutput({tag, " BRESP"},   32'(BRESP),   0);
    checkOutput({tag, " ARREADY"}, 32'(ARREADY), 0);
    checkOutput({tag, " RVALID"},  32'(RVALID),  0);
    checkOutput({tag, " RDATA"},   RDATA,        0);
    checkOutput({tag, " RRESP"},   32'(RRESP),   0);
    checkOutput({tag, " RLAST"},   32'(RLAST),   0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWVALID = 1'b0;
    WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'h0;

    checkOutput("model err 0x0FFC len1", 32'(modelErr('h0FFC, 1, 2)), 1);
    checkOutput("model ok 0x0FFC len0",  32'(modelErr('h0FFC, 0, 2)), 0);
    checkOutput("model ok 0x0FF0 len3",  32'(modelErr('h0FF0, 3, 2)), 0);
    checkOutput("model err 0x0FF8 len3", 32'(modelErr('h0FF8, 3, 2)), 1);
    checkOutput("model err size3",       32'(modelErr('h0, 0, 3)), 1);

    repeat (2) @(posedge ACLK);
    #1;
    checkIdleZero("reset");
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    checkOutput("AWREADY after reset", 32'(AWREADY), 1);
    checkOutput("ARREADY after reset", 32'(ARREADY), 1);

    $display("[TB] single beat write/read");
    gotB.delete(); gotR.delete();
    wBuf[0] = 32'hDEADBEEF;
    applyStimulus(1, 'h0010, 0, 2, -1, -1, 0);
    applyStimulus(0, 'h0010, 0, 2, -1, -1, 0);
    checkOutput("single B count", gotB.size(), 1);
    checkOutput("single BRESP", 32'(gotB[0]), 0);
    checkOutput("single R count", gotR.size(), 1);
    checkOutput("single RDATA", gotR[0].data, 32'hDEADBEEF);
    checkOutput("single RRESP", 32'(gotR[0].resp), 0);
    checkOutput("single RLAST", 32'(gotR[0].last), 1);

    $display("[TB] four beat INCR");
    gotR.delete();
    for (int i = 0; i < 4; i++) wBuf[i] = 32'(i + 1);
    applyStimulus(1, 'h0100, 3, 2, -1, -1, 0);
    applyStimulus(0, 'h0100, 3, 2, -1, -1, 0);
    checkOutput("incr R count", gotR.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("incr RDATA", gotR[i].data, 32'(i + 1));
      checkOutput("incr RLAST", 32'(gotR[i].last), (i == 3) ? 1 : 0);
    end

    $display("[TB] out of range and 4 KB page");
    gotB.delete(); gotR.delete();
    wBuf[0] = 32'hA5A51023;
    applyStimulus(1, 'h0FFC, 0, 2, -1, -1, 0);
    wBuf[0] = 32'h11111111; wBuf[1] = 32'h22222222;
    applyStimulus(1, 'h0FFC, 1, 2, -1, -1, 0);
    checkOutput("range BRESP", 32'(gotB[1]), 2);
    applyStimulus(0, 'h0FFC, 0, 2, -1, -1, 0);
    checkOutput("range RAM[1023] kept", gotR[0].data, 32'hA5A51023);
    applyStimulus(0, 'h0FFC, 1, 2, -1, -1, 0);
    checkOutput("range beat0 RRESP", 32'(gotR[1].resp), 2);
    checkOutput("range beat1 RDATA", gotR[2].data, 0);
    wBuf[0] = 32'hC0; wBuf[1] = 32'hC1; wBuf[2] = 32'hC2;
    applyStimulus(1, 'h0FF0, 2, 2, -1, -1, 0);
    applyStimulus(0, 'h0FF0, 3, 2, -1, -1, 0);
    applyStimulus(0, 'h0FF8, 3, 2, -1, -1, 0);
    checkOutput("page R count", gotR.size(), 11);
    checkOutput("page edge last word", gotR[6].data, 32'hA5A51023);
    checkOutput("page cross RRESP", 32'(gotR[10].resp), 2);

    $display("[TB] size and WLAST errors, narrow beats");
    gotB.delete(); gotR.delete();
    wBuf[0] = 32'h12345678;
    applyStimulus(1, 'h0020, 0, 2, -1, -1, 0);
    wBuf[0] = 32'h00000BAD;
    applyStimulus(1, 'h0020, 0, 3, -1, -1, 0);
    applyStimulus(0, 'h0020, 0, 2, -1, -1, 0);
    checkOutput("size BRESP", 32'(gotB[1]), 2);
    checkOutput("size RAM kept", gotR[0].data, 32'h12345678);
    wBuf[0] = 32'hAA0; wBuf[1] = 32'hAA1; wBuf[2] = 32'hAA2;
    applyStimulus(1, 'h0300, 2, 2, 0, -1, 0);
    applyStimulus(1, 'h0340, 1, 2, 1, -1, 0);
    applyStimulus(0, 'h0300, 2, 2, -1, -1, 0);
    checkOutput("early WLAST BRESP", 32'(gotB[2]), 2);
    checkOutput("missing WLAST BRESP", 32'(gotB[3]), 2);
    checkOutput("early WLAST data kept", gotR[3].data, 32'hAA2);
    wBuf[0] = 32'h0000AAAA; wBuf[1] = 32'h0000BBBB;
    applyStimulus(1, 'h0500, 1, 1, -1, -1, 0);
    applyStimulus(0, 'h0500, 0, 2, -1, -1, 0);
    checkOutput("narrow same word", gotR[4].data, 32'h0000BBBB);

    $display("[TB] backpressure");
    gotB.delete(); gotR.delete();
    wBuf[0] = 32'h77; wBuf[1] = 32'h88;
    applyStimulus(1, 'h0400, 1, 2, -1, -1, 5);
    applyStimulus(0, 'h0100, 3, 2, -1, 1, 3);
    checkOutput("stall BRESP", 32'(gotB[0]), 0);
    checkOutput("stall R count", gotR.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput("stall RDATA", gotR[i].data, 32'(i + 1));

    $display("[TB] reset mid-burst");
    AWADDR = 16'h0200; AWLEN = 8'd3; AWSIZE = 3'd2; AWVALID = 1'b1;
    waitHs(0, "AW abort", 1'b1);
    AWVALID = 1'b0;
    WDATA = 32'hCAFE0000; WLAST = 1'b0; WVALID = 1'b1;
    waitHs(1, "W abort", 1'b1);
    modelMem['h80] = 32'hCAFE0000;
    WDATA = 32'hCAFE0001;
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    checkIdleZero("async reset");
    WVALID = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    checkOutput("AWREADY after abort", 32'(AWREADY), 1);
    gotB.delete(); gotR.delete();
    wBuf[0] = 32'h600DF00D;
    applyStimulus(1, 'h0210, 0, 2, -1, -1, 0);
    applyStimulus(0, 'h0200, 0, 2, -1, -1, 0);
    applyStimulus(0, 'h0210, 0, 2, -1, -1, 0);
    checkOutput("fresh BRESP", 32'(gotB[0]), 0);
    checkOutput("aborted beat kept", gotR[0].data, 32'hCAFE0000);
    checkOutput("fresh data", gotR[1].data, 32'h600DF00D);

    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("R queue drained", expR.size(), 0);
    checkOutput("B queue drained", expB.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
